// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if
//   Bundles the exception-report, flush/redirect and CSR-access signals that
//   pass between the pipeline and the machine-mode trap sequencer.
//   Modports:
//     master - pipeline side: drives exception reports, mtvec, flush_done,
//              redirect_ready and CSR accesses; observes flush/redirect/CSR read.
//     slave  - trap_ctrl side: the reverse direction of every signal.
//   Signals:
//     if_exc_valid/cause/pc/tval  ifetch exception report
//     ex_exc_valid/cause/pc/tval  exec exception report
//     mtvec                       current trap vector CSR
//     flush_done                  all pipeline stages drained
//     flush                       kill all in-flight instructions
//     redirect_valid/ready/pc     PC redirect handshake to ifetch
//     csr_addr/wen/wdata          CSR access from exec
//     csr_hit/csr_rdata           CSR decode and combinational read data
interface trap_ctrl_if #(
  parameter int XLEN    = 32,
  parameter int CAUSE_W = 5
);
  logic               if_exc_valid;
  logic [CAUSE_W-1:0] if_exc_cause;
  logic [XLEN-1:0]    if_exc_pc;
  logic [XLEN-1:0]    if_exc_tval;
  logic               ex_exc_valid;
  logic [CAUSE_W-1:0] ex_exc_cause;
  logic [XLEN-1:0]    ex_exc_pc;
  logic [XLEN-1:0]    ex_exc_tval;
  logic [XLEN-1:0]    mtvec;
  logic               flush_done;
  logic               redirect_ready;
  logic               flush;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic [11:0]        csr_addr;
  logic               csr_wen;
  logic [XLEN-1:0]    csr_wdata;
  logic               csr_hit;
  logic [XLEN-1:0]    csr_rdata;

  modport master (
    output if_exc_valid, if_exc_cause, if_exc_pc, if_exc_tval,
    output ex_exc_valid, ex_exc_cause, ex_exc_pc, ex_exc_tval,
    output mtvec, flush_done, redirect_ready,
    output csr_addr, csr_wen, csr_wdata,
    input  flush, redirect_valid, redirect_pc, csr_hit, csr_rdata
  );

  modport slave (
    input  if_exc_valid, if_exc_cause, if_exc_pc, if_exc_tval,
    input  ex_exc_valid, ex_exc_cause, ex_exc_pc, ex_exc_tval,
    input  mtvec, flush_done, redirect_ready,
    input  csr_addr, csr_wen, csr_wdata,
    output flush, redirect_valid, redirect_pc, csr_hit, csr_rdata
  );
endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl
//   Machine-mode synchronous-exception sequencer. Captures an exception report
//   from exec (preferred) or ifetch into mepc/mcause/mtval, flushes the
//   pipeline, then issues one PC redirect to the mtvec base address.
//   Also serves reads/writes of mepc (0x341), mcause (0x342), mtval (0x343).
//   Ports:
//     clk  - core clock
//     rst  - asynchronous reset, active-high
//     bus  - trap_ctrl_if.slave: exception reports, flush/redirect handshake,
//            CSR access (see trap_ctrl_if for the signal list)
module trap_ctrl #(
  parameter int XLEN    = 32,
  parameter int CAUSE_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  trap_ctrl_if.slave   bus
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  localparam logic [11:0] ADDR_MEPC   = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE = 12'h342;
  localparam logic [11:0] ADDR_MTVAL  = 12'h343;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mtval;
  logic [XLEN-1:0] redirect_pc_q;
  logic            capture;
  logic            csr_write;

  // Reports only matter in IDLE; anything arriving in FLUSH/REDIRECT belongs
  // to an instruction that is being killed.
  assign capture   = (state == IDLE) && (bus.ex_exc_valid || bus.if_exc_valid);
  // A trap capture in the same cycle owns all three registers.
  assign csr_write = (state == IDLE) && bus.csr_wen && bus.csr_hit && !capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (capture) next_state = FLUSH;
      FLUSH:    if (bus.flush_done) next_state = REDIRECT;
      REDIRECT: if (bus.redirect_ready) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.flush          = (state == FLUSH);
    bus.redirect_valid = (state == REDIRECT);
  end

  assign bus.redirect_pc = redirect_pc_q;

  // Exec is the older instruction, so its report wins a simultaneous capture.
  // The handler base ignores mtvec.MODE for exceptions, hence the masking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mepc          <= '0;
      mcause        <= '0;
      mtval         <= '0;
      redirect_pc_q <= '0;
    end else if (capture) begin
      redirect_pc_q <= bus.mtvec & ALIGN_MASK;
      if (bus.ex_exc_valid) begin
        mepc   <= bus.ex_exc_pc & ALIGN_MASK;
        mcause <= XLEN'(bus.ex_exc_cause);
        mtval  <= bus.ex_exc_tval;
      end else begin
        mepc   <= bus.if_exc_pc & ALIGN_MASK;
        mcause <= XLEN'(bus.if_exc_cause);
        mtval  <= bus.if_exc_tval;
      end
    end else if (csr_write) begin
      case (bus.csr_addr)
        ADDR_MEPC:   mepc   <= bus.csr_wdata & ALIGN_MASK;
        ADDR_MCAUSE: mcause <= bus.csr_wdata;
        ADDR_MTVAL:  mtval  <= bus.csr_wdata;
        default:     ;
      endcase
    end
  end

  // Read data is the pre-edge register value, which gives CSRRW swap behaviour.
  always_comb begin
    bus.csr_hit   = 1'b0;
    bus.csr_rdata = '0;
    case (bus.csr_addr)
      ADDR_MEPC:   begin bus.csr_hit = 1'b1; bus.csr_rdata = mepc;   end
      ADDR_MCAUSE: begin bus.csr_hit = 1'b1; bus.csr_rdata = mcause; end
      ADDR_MTVAL:  begin bus.csr_hit = 1'b1; bus.csr_rdata = mtval;  end
      default:     ;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl
//   Randomized scoreboard bench for trap_ctrl. Each issued trap pushes the
//   expected redirect (handler address, flush length, redirect-valid length)
//   into a queue; an independent monitor pops and compares on every redirect
//   handshake. CSR contents are checked against a plain reference model of
//   the architectural trap rules.
module tb_trap_ctrl;

  logic clk;
  logic rst;

  trap_ctrl_if #(.XLEN(32), .CAUSE_W(5)) bus ();

  trap_ctrl #(.XLEN(32), .CAUSE_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] pc;
    int          flush_n;
    int          valid_n;
  } exp_t;

  exp_t        exp_q[$];
  int          checks;
  int          fails;
  logic [31:0] m_mepc;
  logic [31:0] m_mcause;
  logic [31:0] m_mtval;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] addr);
    case (addr)
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit model_hit(input logic [11:0] addr);
    return (addr == 12'h341) || (addr == 12'h342) || (addr == 12'h343);
  endfunction

  // Monitor: counts flush and redirect-valid cycles of the current trap and
  // checks each redirect handshake against the head of the queue.
  int          flush_cnt;
  int          valid_cnt;
  logic [31:0] first_pc;

  always @(negedge clk) begin
    if (rst) begin
      flush_cnt = 0;
      valid_cnt = 0;
    end else begin
      if (bus.flush) flush_cnt++;
      if (bus.redirect_valid) begin
        if (valid_cnt == 0) first_pc = bus.redirect_pc;
        else checkOutput("redirect_pc_stable", bus.redirect_pc, first_pc);
        valid_cnt++;
        if (bus.redirect_ready) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_redirect", 32'(bus.redirect_valid), 32'h0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("redirect_pc", bus.redirect_pc, e.pc);
            checkOutput("flush_cycles", 32'(flush_cnt), 32'(e.flush_n));
            checkOutput("redirect_cycles", 32'(valid_cnt), 32'(e.valid_n));
          end
          flush_cnt = 0;
          valid_cnt = 0;
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.if_exc_valid   = 1'b0;
    bus.if_exc_cause   = '0;
    bus.if_exc_pc      = '0;
    bus.if_exc_tval    = '0;
    bus.ex_exc_valid   = 1'b0;
    bus.ex_exc_cause   = '0;
    bus.ex_exc_pc      = '0;
    bus.ex_exc_tval    = '0;
    bus.mtvec          = '0;
    bus.flush_done     = 1'b0;
    bus.redirect_ready = 1'b0;
    bus.csr_addr       = '0;
    bus.csr_wen        = 1'b0;
    bus.csr_wdata      = '0;
  endtask

  // Reads one CSR through the combinational port and compares to the model.
  task automatic check_csr(input logic [11:0] addr);
    bus.csr_addr = addr;
    bus.csr_wen  = 1'b0;
    #1;
    checkOutput($sformatf("csr_rdata_%03h", addr), bus.csr_rdata, model_read(addr));
    checkOutput($sformatf("csr_hit_%03h", addr), 32'(bus.csr_hit), 32'(model_hit(addr)));
  endtask

  // IDLE-state CSR write: read data shows the old value during the write cycle.
  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    bus.csr_addr  = addr;
    bus.csr_wdata = data;
    bus.csr_wen   = 1'b1;
    #1;
    checkOutput("csr_rdata_during_write", bus.csr_rdata, model_read(addr));
    @(posedge clk); #1;
    bus.csr_wen = 1'b0;
    case (addr)
      12'h341: m_mepc   = data & ~32'h3;
      12'h342: m_mcause = data;
      12'h343: m_mtval  = data;
      default: ;
    endcase
  endtask

  // One complete trap. Entered and left at posedge+1 with the DUT in IDLE.
  task automatic applyStimulus(
    input bit ifv, input logic [4:0] ifc, input logic [31:0] ifpc, input logic [31:0] iftv,
    input bit exv, input logic [4:0] exc, input logic [31:0] expc, input logic [31:0] extv,
    input logic [31:0] mtvec_v, input int flush_len, input int wait_len,
    input bit inject, input logic [11:0] collide_addr, input logic [31:0] collide_data);
    exp_t e;
    bus.if_exc_valid = ifv; bus.if_exc_cause = ifc; bus.if_exc_pc = ifpc; bus.if_exc_tval = iftv;
    bus.ex_exc_valid = exv; bus.ex_exc_cause = exc; bus.ex_exc_pc = expc; bus.ex_exc_tval = extv;
    bus.mtvec = mtvec_v;
    if (collide_addr != 12'h0) begin
      bus.csr_addr = collide_addr; bus.csr_wdata = collide_data; bus.csr_wen = 1'b1;
    end
    if (exv) begin
      m_mepc = expc & ~32'h3; m_mcause = {27'h0, exc}; m_mtval = extv;
    end else if (ifv) begin
      m_mepc = ifpc & ~32'h3; m_mcause = {27'h0, ifc}; m_mtval = iftv;
    end
    e.pc = mtvec_v & ~32'h3;
    e.flush_n = flush_len;
    e.valid_n = wait_len + 1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.if_exc_valid = 1'b0;
    bus.ex_exc_valid = 1'b0;
    bus.csr_wen      = 1'b0;
    bus.mtvec        = $urandom;
    if (inject) begin
      bus.ex_exc_valid = 1'b1; bus.ex_exc_cause = 5'($urandom);
      bus.ex_exc_pc = $urandom; bus.ex_exc_tval = $urandom;
      bus.csr_addr = 12'h341; bus.csr_wdata = $urandom; bus.csr_wen = 1'b1;
    end
    for (int i = 0; i < flush_len; i++) begin
      if (i == flush_len - 1) bus.flush_done = 1'b1;
      @(posedge clk); #1;
      bus.ex_exc_valid = 1'b0;
      bus.csr_wen      = 1'b0;
      bus.flush_done   = 1'b0;
    end
    for (int i = 0; i < wait_len; i++) begin
      @(posedge clk); #1;
    end
    bus.redirect_ready = 1'b1;
    @(posedge clk); #1;
    bus.redirect_ready = 1'b0;
    check_csr(12'h341);
    check_csr(12'h342);
    check_csr(12'h343);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    fails  = 0;
    m_mepc = 0; m_mcause = 0; m_mtval = 0;
    idle_inputs();
    rst = 1'b1;
    #1;
    checkOutput("reset_flush", 32'(bus.flush), 32'h0);
    checkOutput("reset_redirect_valid", 32'(bus.redirect_valid), 32'h0);
    checkOutput("reset_redirect_pc", bus.redirect_pc, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check_csr(12'h341);
    check_csr(12'h342);
    check_csr(12'h343);

    $display("[TB] directed: ifetch trap, mtvec MODE bits masked");
    applyStimulus(1'b1, 5'd2, 32'h4, 32'hFFF0217F, 1'b0, 5'd0, 32'h0, 32'h0,
                  32'h0E, 3, 0, 1'b0, 12'h0, 32'h0);
    $display("[TB] directed: exec trap");
    applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd2, 32'h14, 32'hF11FD073,
                  32'h1F, 2, 0, 1'b0, 12'h0, 32'h0);
    $display("[TB] directed: simultaneous reports, exec wins");
    applyStimulus(1'b1, 5'd1, 32'h20, 32'hAAAA5555, 1'b1, 5'd3, 32'h18, 32'h12345678,
                  32'h100, 1, 0, 1'b0, 12'h0, 32'h0);
    $display("[TB] directed: report during FLUSH, ready held low");
    applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd7, 32'h33, 32'hCAFEF00D,
                  32'h203, 2, 4, 1'b1, 12'h0, 32'h0);
    $display("[TB] directed: CSR write and trap/CSR collision");
    csr_write(12'h341, 32'h1237);
    check_csr(12'h341);
    applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd11, 32'h40, 32'hDEADBEEF,
                  32'h80, 1, 1, 1'b0, 12'h342, 32'h5A5A5A5A);

    $display("[TB] directed: reset during FLUSH");
    bus.csr_addr     = 12'h341;
    bus.ex_exc_valid = 1'b1; bus.ex_exc_cause = 5'd4; bus.ex_exc_pc = 32'h60;
    bus.ex_exc_tval  = 32'h1; bus.mtvec = 32'h400;
    @(posedge clk); #1;
    bus.ex_exc_valid = 1'b0;
    checkOutput("flush_before_reset", 32'(bus.flush), 32'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("flush_on_reset", 32'(bus.flush), 32'h0);
    checkOutput("mepc_on_reset", bus.csr_rdata, 32'h0);
    m_mepc = 0; m_mcause = 0; m_mtval = 0;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.flush_done = 1'b1;
    bus.redirect_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("no_redirect_after_reset", 32'(bus.redirect_valid), 32'h0);
      checkOutput("no_flush_after_reset", 32'(bus.flush), 32'h0);
    end
    bus.flush_done = 1'b0;
    bus.redirect_ready = 1'b0;

    $display("[TB] random traps and CSR accesses");
    for (int n = 0; n < 40; n++) begin
      int sel;
      logic [11:0] a;
      sel = $urandom_range(1, 3);
      applyStimulus(sel[0], 5'($urandom), $urandom, $urandom,
                    sel[1], 5'($urandom), $urandom, $urandom,
                    $urandom, $urandom_range(1, 4), $urandom_range(0, 3),
                    1'($urandom), ($urandom_range(0, 1) == 1) ? 12'(12'h341 + $urandom_range(0, 2)) : 12'h0,
                    $urandom);
      a = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'(12'h341 + $urandom_range(0, 2));
      csr_write(a, $urandom);
      check_csr(a);
    end

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
